stream_alpha_lifo: RTL

//  - Buffers one frame of forward (alpha) state metrics, one vector of STATES metrics per trellis step.
//  - Replays the frame in reverse step order so the backward pass sees the matching alpha.
//  - Sits between the alpha recursion and the per-state max-product LLR stages.
//  - Each alpha_out[s] drives the AlphaMetric input of state s's LLR stage.

---
 rtl/turbo_pkg.sv | 17 +
 rtl/lifo_ram.sv | 35 +++
 rtl/stream_alpha_lifo.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/turbo_pkg.sv
// Shared types for the turbo decoder datapath: metric words, per-step alpha
// vectors and the alpha LIFO state encoding.
package turbo_pkg;

    localparam int BITS   = 16;
    localparam int STATES = 4;
    localparam int DEPTH  = 64;

    typedef logic [BITS-1:0] metric_t;
    typedef metric_t alpha_vec_t [STATES];

    typedef enum logic {
        WRITE = 1'b0,
        READ  = 1'b1
    } lifo_state_t;

endpackage

// File: rtl/lifo_ram.sv
// Simple dual-port RAM holding one frame of alpha vectors: one write port and
// a registered read port. Only the read register is reset, never the array.
module lifo_ram #(
    parameter int WIDTH  = 64,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // The read register doubles as the LIFO output register, so it resets to zero.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/stream_alpha_lifo.sv
// Alpha-metric LIFO: stores one frame of forward metrics and replays it in
// reverse step order. Optional frame_len port enabled by ALPHA_LIFO_FRAME_LEN_EN.
module stream_alpha_lifo
    import turbo_pkg::*;
#(
    parameter  int BITS   = turbo_pkg::BITS,
    parameter  int STATES = turbo_pkg::STATES,
    parameter  int DEPTH  = turbo_pkg::DEPTH,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [BITS-1:0] alpha_in [STATES],
    input  logic            in_last,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [BITS-1:0] alpha_out [STATES],
    output logic            out_last,
    output logic            overflow
`ifdef ALPHA_LIFO_FRAME_LEN_EN
    ,
    output logic [ADDR_W:0] frame_len
`endif
);

    localparam int WIDTH = BITS * STATES;

    lifo_state_t       state;
    lifo_state_t       next_state;
    logic [ADDR_W-1:0] wr_cnt;
    logic [ADDR_W-1:0] rd_ptr;
    logic              rd_done;
    logic [WIDTH-1:0]  wdata;
    logic [WIDTH-1:0]  rdata;
    logic              in_fire;
    logic              out_fire;
    logic              at_limit;
    logic              frame_end;
    logic              rd_issue;

    always_comb begin
        wdata = '0;
        for (int s = 0; s < STATES; s++) begin
            wdata[s*BITS +: BITS] = alpha_in[s];
            alpha_out[s]          = rdata[s*BITS +: BITS];
        end
    end

    // A read is only issued when the output register is free or draining this
    // cycle, so one output register suffices without a skid buffer.
    always_comb begin
        next_state = state;
        in_ready   = (state == WRITE);
        in_fire    = in_valid && in_ready;
        out_fire   = out_valid && out_ready;
        at_limit   = (wr_cnt == ADDR_W'(DEPTH - 1));
        frame_end  = in_fire && (in_last || at_limit);
        rd_issue   = (state == READ) && !rd_done && (!out_valid || out_ready);
        case (state)
            WRITE: if (frame_end) next_state = READ;
            READ:  if (out_fire && out_last) next_state = WRITE;
            default: next_state = WRITE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= WRITE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_cnt    <= '0;
            rd_ptr    <= '0;
            rd_done   <= 1'b1;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (frame_end) begin
                rd_ptr  <= wr_cnt;
                rd_done <= 1'b0;
                if (!in_last) begin
                    overflow <= 1'b1;
                end
            end else if (in_fire) begin
                wr_cnt <= wr_cnt + 1'b1;
            end

            if (rd_issue) begin
                out_valid <= 1'b1;
                out_last  <= (rd_ptr == '0);
                if (rd_ptr == '0) begin
                    rd_done <= 1'b1;
                end else begin
                    rd_ptr <= rd_ptr - 1'b1;
                end
            end else if (out_fire) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end

            if (out_fire && out_last) begin
                wr_cnt <= '0;
            end
        end
    end

`ifdef ALPHA_LIFO_FRAME_LEN_EN
    always_ff @(posedge clk) begin
        if (!rstn) begin
            frame_len <= '0;
        end else if (frame_end) begin
            frame_len <= {1'b0, wr_cnt} + 1'b1;
        end
    end
`else
`endif

    lifo_ram #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .rstn  (rstn),
        .we    (in_fire),
        .waddr (wr_cnt),
        .wdata (wdata),
        .re    (rd_issue),
        .raddr (rd_ptr),
        .rdata (rdata)
    );

endmodule
